// File: rtl/riscv_ifetch_req_ctrl.sv
// Instruction-fetch request controller: drives IRAM rden/addr, captures mem_rdata on mem_ready.
// Optional read timeout is enabled with `define IFETCH_TIMEOUT_EN.
module riscv_ifetch_req_ctrl #(
  parameter int ADDR_W   = 64,
  parameter int INST_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rden,
  output logic [ADDR_W-1:0] addr,
  input  logic              mem_ready,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic              stall,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  if (MAX_WAIT < 5) begin : g_bad_cfg
    $error("riscv_ifetch_req_ctrl: MAX_WAIT must be >= 5");
  end

  logic [1:0]        r_state;
  logic              r_rden;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst;

`ifdef IFETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic              r_err;
  logic [WAIT_W-1:0] r_wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rden       <= 1'b0;
      r_addr       <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
`ifdef IFETCH_TIMEOUT_EN
      r_err        <= 1'b0;
      r_wait_cnt   <= '0;
`endif
    end else begin
      r_inst_valid <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      r_err        <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // flush outranks a new request; mem_ready here is stray and ignored
          if (req_valid && !flush) begin
            r_addr  <= req_addr;
            r_rden  <= 1'b1;
            r_state <= ST_REQ;
`ifdef IFETCH_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (flush) begin
            r_rden  <= 1'b0;
            r_state <= ST_GAP;
          end else if (mem_ready) begin
            r_inst       <= mem_rdata;
            r_inst_valid <= 1'b1;
            r_rden       <= 1'b0;
            r_state      <= ST_GAP;
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            r_rden  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        // one rden-low cycle lets the responder rearm before the next read
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rden       = r_rden;
  assign addr       = r_addr;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign stall      = (r_state == ST_REQ) | (r_state == ST_GAP);

`ifdef IFETCH_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_ifetch_req_ctrl.sv
// Directed bench for riscv_ifetch_req_ctrl against a 4-cycle IRAM responder model.
// Timeout expectations follow IFETCH_TIMEOUT_EN.
module tb_riscv_ifetch_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        flush;
  logic        rden;
  logic [63:0] addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        stall;
  logic        err;

  logic        resp_en    = 1'b1;
  logic        resp_rdy   = 1'b0;
  logic [31:0] resp_rdata = '0;
  int          resp_cnt   = 0;
  int          comp_cnt   = 0;
  logic        force_rdy  = 1'b0;
  logic [31:0] force_data = '0;

  int n_chk  = 0;
  int n_fail = 0;

  riscv_ifetch_req_ctrl #(.ADDR_W(64), .INST_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .rden(rden), .addr(addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_fn(input logic [63:0] a);
    if (a == 64'h1000) return 32'h0050_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  // IRAM model: mem_ready pulses once after rden has been seen at 4 edges
  always @(posedge clk) begin
    resp_rdy <= 1'b0;
    if (!rden) begin
      resp_cnt <= 0;
    end else if (resp_cnt == 3 && resp_en) begin
      resp_rdy   <= 1'b1;
      resp_rdata <= data_fn(addr);
      resp_cnt   <= 4;
      comp_cnt   <= comp_cnt + 1;
    end else if (resp_cnt < 3) begin
      resp_cnt <= resp_cnt + 1;
    end
  end

  assign mem_ready = resp_rdy | force_rdy;
  assign mem_rdata = force_rdy ? force_data : resp_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic any_iv;
    logic found;
    logic prev_iv;
    int   n_acc, n_iv, last_iv, comp_base;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rden", rden, 0);
    chk("rst_addr", addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch: accept at E0, k = cycles after E0
    req_valid = 1'b1; req_addr = 64'h1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("single_rden_%0d", k), rden, (k <= 4));
      chk($sformatf("single_stall_%0d", k), stall, (k <= 5));
      chk($sformatf("single_iv_%0d", k), inst_valid, (k == 5));
      if (k <= 4) chk($sformatf("single_addr_%0d", k), addr, 64'h1000);
      if (k == 0) req_valid = 1'b0;
    end
    chk("single_inst", inst, 32'h0050_0093);

    // back-to-back requests at 0x0, 0x4, 0x8
    n_acc = 0; n_iv = 0; last_iv = -100; prev_iv = 1'b0; comp_base = comp_cnt;
    for (int c = 0; c < 40; c++) begin
      if (n_acc < 3) begin
        req_valid = 1'b1;
        if (!stall) begin
          req_addr = 64'(4 * n_acc);
          n_acc++;
        end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (inst_valid) begin
        chk($sformatf("b2b_inst_%0d", n_iv), inst, data_fn(64'(4 * n_iv)));
        chk($sformatf("b2b_single_pulse_%0d", n_iv), prev_iv, 0);
        if (n_iv > 0) chk($sformatf("b2b_spacing_%0d", n_iv), (c - last_iv) >= 6, 1);
        last_iv = c;
        n_iv++;
      end
      prev_iv = inst_valid;
    end
    chk("b2b_pulses", n_iv, 3);
    chk("b2b_completions", comp_cnt - comp_base, 3);

    // flush during the second REQ cycle
    comp_base = comp_cnt;
    req_valid = 1'b1; req_addr = 64'h3000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rden", rden, 0);
    chk("flush_gap_stall", stall, 1);
    @(negedge clk);
    chk("flush_idle_stall", stall, 0);
    any_iv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_iv |= inst_valid;
    end
    chk("flush_no_iv", any_iv, 0);
    chk("flush_no_completion", comp_cnt - comp_base, 0);

    req_valid = 1'b1; req_addr = 64'h2000;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (inst_valid) found = 1'b1;
    end
    chk("after_flush_found", found, 1);
    chk("after_flush_inst", inst, 32'hC0DE_2000);
    @(negedge clk);

    // flush on the same cycle as mem_ready
    req_valid = 1'b1; req_addr = 64'h4000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rdy_iv", inst_valid, 0);
    chk("flush_rdy_inst", inst, 32'hC0DE_2000);
    chk("flush_rdy_rden", rden, 0);
    chk("flush_rdy_gap", stall, 1);
    @(negedge clk);
    chk("flush_rdy_idle", stall, 0);
    chk("flush_rdy_iv2", inst_valid, 0);

    // reset during REQ
    req_valid = 1'b1; req_addr = 64'h5000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_rden", rden, 0);
    chk("midrst_inst", inst, 0);
    chk("midrst_stall", stall, 0);
    any_iv = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_iv |= inst_valid;
    end
    chk("midrst_no_iv", any_iv, 0);

    // stray mem_ready while idle
    force_data = 32'hDEAD_BEEF; force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    chk("stray_rdy_iv", inst_valid, 0);
    chk("stray_rdy_inst", inst, 0);
    chk("stray_rdy_stall", stall, 0);

    // responder never completes
    resp_en = 1'b0;
    req_valid = 1'b1; req_addr = 64'h6000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      chk($sformatf("tmo_iv_%0d", k), inst_valid, 0);
`ifdef IFETCH_TIMEOUT_EN
      chk($sformatf("tmo_err_%0d", k), err, (k == 8));
      chk($sformatf("tmo_rden_%0d", k), rden, (k <= 7));
`else
      chk($sformatf("tmo_err_%0d", k), err, 0);
      chk($sformatf("tmo_rden_%0d", k), rden, 1);
`endif
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("tmo_end_stall", stall, 0);
    chk("tmo_end_rden", rden, 0);
    resp_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
